// File: rtl/tensor_core_pkg.sv
// -----------------------------------------------------------------------------
// tensor_core_pkg
//   Definitions shared by the tensor core burst controller and the memory
//   controller that feeds it: instruction opcodes, burst select codes, the
//   controller state encoding, the register-file geometry and an address
//   wrap helper.
// -----------------------------------------------------------------------------
package tensor_core_pkg;

    // Instruction opcodes, decoded from instr_in[1:0] while idle.
    localparam logic [1:0] OP_NOP     = 2'b00;
    localparam logic [1:0] OP_OPERATE = 2'b01;
    localparam logic [1:0] OP_BURST   = 2'b10;
    localparam logic [1:0] OP_RESET   = 2'b11;

    // Burst direction, decoded from header bits [3:2].
    localparam logic [1:0] SEL_READ  = 2'b00;
    localparam logic [1:0] SEL_WRITE = 2'b01;

    // Register file: three row-major 3x3 matrices of signed bytes.
    localparam int REG_COUNT = 27;
    localparam int A_BASE    = 0;
    localparam int B_BASE    = 9;
    localparam int C_BASE    = 18;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_BURST_WRITE = 2'd1,
        ST_BURST_READ  = 2'd2,
        ST_COMPUTE     = 2'd3
    } tc_state_t;

    // Reduce an address that may have stepped past the top of the register
    // file (at most by 2) back into 0..REG_COUNT-1.
    function automatic logic [4:0] addr_wrap(input logic [5:0] addr);
        logic [4:0] wrapped;
        if (addr >= 6'(REG_COUNT)) begin
            wrapped = 5'(addr - 6'(REG_COUNT));
        end else begin
            wrapped = addr[4:0];
        end
        return wrapped;
    endfunction

endpackage

// File: rtl/tensor_core_mac3.sv
// -----------------------------------------------------------------------------
// tensor_core_mac3
//   Combinational 3-term signed dot product a0*b0 + a1*b1 + a2*b2, evaluated
//   at ACC_WIDTH bits and saturated to the signed byte range [-128, 127].
//
// Ports
//   a0..a2  in   DATA_WIDTH  signed row operands
//   b0..b2  in   DATA_WIDTH  signed column operands
//   result  out  8           saturated signed byte
// -----------------------------------------------------------------------------
module tensor_core_mac3 #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 20
) (
    input  logic [DATA_WIDTH-1:0] a0,
    input  logic [DATA_WIDTH-1:0] a1,
    input  logic [DATA_WIDTH-1:0] a2,
    input  logic [DATA_WIDTH-1:0] b0,
    input  logic [DATA_WIDTH-1:0] b1,
    input  logic [DATA_WIDTH-1:0] b2,
    output logic [7:0]            result
);

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(127);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(-128);

    logic signed [ACC_WIDTH-1:0] prod0;
    logic signed [ACC_WIDTH-1:0] prod1;
    logic signed [ACC_WIDTH-1:0] prod2;
    logic signed [ACC_WIDTH-1:0] sum;

    always_comb begin
        // Operands are sign-extended to the accumulator width before the
        // multiply so the product is not truncated to DATA_WIDTH bits.
        prod0 = ACC_WIDTH'($signed(a0)) * ACC_WIDTH'($signed(b0));
        prod1 = ACC_WIDTH'($signed(a1)) * ACC_WIDTH'($signed(b1));
        prod2 = ACC_WIDTH'($signed(a2)) * ACC_WIDTH'($signed(b2));
        sum   = prod0 + prod1 + prod2;

        if (sum > SAT_MAX) begin
            result = 8'h7F;
        end else if (sum < SAT_MIN) begin
            result = 8'h80;
        end else begin
            result = sum[7:0];
        end
    end

endmodule

// File: rtl/tensor_core_burst_controller.sv
// -----------------------------------------------------------------------------
// tensor_core_burst_controller
//   Holds three 3x3 signed byte matrices (A at 0-8, B at 9-17, C at 18-26).
//   Accepts instructions from the memory controller: burst write/read of the
//   register file, a matrix multiply C = sat8(A x B) computed one element per
//   cycle, and a soft reset that clears the register file and error flag.
//
// Ports
//   clock_in                 in   1   clock, rising edge
//   reset_n_in               in   1   asynchronous active-low reset
//   instr_in                 in   16  instruction / burst data word
//   instr_valid_in           in   1   instr_in is sampled this edge
//   controller_output        out  8   read-back byte, 0 when not valid
//   controller_output_valid  out  1   controller_output carries a read byte
//   busy_out                 out  1   high in every state except IDLE
//   done_out                 out  1   one-cycle pulse after a compute
//   error_out                out  1   sticky protocol-error flag
//   state_dbg                out  2   current FSM state (tc_state_t encoding)
//
// Input protocol: instr_valid_in qualifies instr_in on every rising edge.
// There is no back-pressure; the controller never stalls its source. Words
// that arrive while a read burst or a compute is running are dropped, and a
// dropped word that is nonzero raises error_out.
// -----------------------------------------------------------------------------
module tensor_core_burst_controller
    import tensor_core_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 20
) (
    input  logic        clock_in,
    input  logic        reset_n_in,
    input  logic [15:0] instr_in,
    input  logic        instr_valid_in,
    output logic [7:0]  controller_output,
    output logic        controller_output_valid,
    output logic        busy_out,
    output logic        done_out,
    output logic        error_out,
    output logic [1:0]  state_dbg
);

    tc_state_t  state_q;
    tc_state_t  state_d;

    logic [7:0] regs [REG_COUNT];
    logic [4:0] addr_q;
    logic [4:0] cnt_q;
    logic [1:0] row_q;
    logic [1:0] col_q;

    // Instruction / burst header fields.
    logic [1:0] opcode;
    logic [1:0] hdr_sel;
    logic [4:0] hdr_start;
    logic [4:0] hdr_cnt;
    logic       hdr_bad;
    logic       err_set;
    logic       compute_last;

    // Matrix-multiply operand addressing for the current C element.
    logic [4:0] row_x3;
    logic [4:0] a_idx0;
    logic [4:0] a_idx1;
    logic [4:0] a_idx2;
    logic [4:0] b_idx0;
    logic [4:0] b_idx1;
    logic [4:0] b_idx2;
    logic [4:0] c_idx;
    logic [7:0] mac_result;

    assign opcode    = instr_in[1:0];
    assign hdr_sel   = instr_in[3:2];
    assign hdr_start = instr_in[8:4];
    assign hdr_cnt   = instr_in[13:9];
    assign hdr_bad   = ((hdr_sel != SEL_READ) && (hdr_sel != SEL_WRITE)) ||
                       (hdr_start > 5'(REG_COUNT - 1));

    assign compute_last = (row_q == 2'd2) && (col_q == 2'd2);

    // A bad header in IDLE, or any nonzero word that is dropped because the
    // controller is reading out or computing, flags a protocol error.
    always_comb begin
        err_set = 1'b0;
        if (instr_valid_in) begin
            if ((state_q == ST_IDLE) && (opcode == OP_BURST) && hdr_bad) begin
                err_set = 1'b1;
            end
            if (((state_q == ST_BURST_READ) || (state_q == ST_COMPUTE)) &&
                (instr_in != 16'h0000)) begin
                err_set = 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (instr_valid_in) begin
                    if (opcode == OP_OPERATE) begin
                        state_d = ST_COMPUTE;
                    end else if ((opcode == OP_BURST) && !hdr_bad &&
                                 (hdr_cnt != 5'd0)) begin
                        state_d = (hdr_sel == SEL_WRITE) ? ST_BURST_WRITE
                                                         : ST_BURST_READ;
                    end
                end
            end
            ST_BURST_WRITE: begin
                // Waits for data indefinitely; only valid words count.
                if (instr_valid_in && (cnt_q == 5'd1)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_BURST_READ: begin
                if (cnt_q == 5'd1) begin
                    state_d = ST_IDLE;
                end
            end
            ST_COMPUTE: begin
                if (compute_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy_out  = (state_q != ST_IDLE);
    assign state_dbg = state_q;

    // ------------------------------------------------------ MAC addressing
    always_comb begin
        row_x3 = 5'({row_q, 1'b0}) + 5'(row_q);
        a_idx0 = 5'(A_BASE) + row_x3;
        a_idx1 = a_idx0 + 5'd1;
        a_idx2 = a_idx0 + 5'd2;
        b_idx0 = 5'(B_BASE) + 5'(col_q);
        b_idx1 = b_idx0 + 5'd3;
        b_idx2 = b_idx0 + 5'd6;
        c_idx  = 5'(C_BASE) + row_x3 + 5'(col_q);
    end

    tensor_core_mac3 #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_mac3 (
        .a0     (DATA_WIDTH'($signed(regs[a_idx0]))),
        .a1     (DATA_WIDTH'($signed(regs[a_idx1]))),
        .a2     (DATA_WIDTH'($signed(regs[a_idx2]))),
        .b0     (DATA_WIDTH'($signed(regs[b_idx0]))),
        .b1     (DATA_WIDTH'($signed(regs[b_idx1]))),
        .b2     (DATA_WIDTH'($signed(regs[b_idx2]))),
        .result (mac_result)
    );

    // ------------------------------------------------------------ datapath
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= 8'h00;
            end
            addr_q                  <= 5'd0;
            cnt_q                   <= 5'd0;
            row_q                   <= 2'd0;
            col_q                   <= 2'd0;
            controller_output       <= 8'h00;
            controller_output_valid <= 1'b0;
            done_out                <= 1'b0;
            error_out               <= 1'b0;
        end else begin
            // Read-back byte and done are single-cycle unless re-asserted.
            controller_output       <= 8'h00;
            controller_output_valid <= 1'b0;
            done_out                <= 1'b0;

            if (err_set) begin
                error_out <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (instr_valid_in) begin
                        case (opcode)
                            OP_OPERATE: begin
                                row_q <= 2'd0;
                                col_q <= 2'd0;
                            end
                            OP_BURST: begin
                                addr_q <= hdr_start;
                                cnt_q  <= hdr_cnt;
                            end
                            OP_RESET: begin
                                for (int i = 0; i < REG_COUNT; i++) begin
                                    regs[i] <= 8'h00;
                                end
                                error_out <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_BURST_WRITE: begin
                    if (instr_valid_in) begin
                        regs[addr_q]                          <= instr_in[15:8];
                        regs[addr_wrap({1'b0, addr_q} + 6'd1)] <= instr_in[7:0];
                        addr_q <= addr_wrap({1'b0, addr_q} + 6'd2);
                        cnt_q  <= cnt_q - 5'd1;
                    end
                end
                ST_BURST_READ: begin
                    controller_output       <= regs[addr_q];
                    controller_output_valid <= 1'b1;
                    addr_q <= addr_wrap({1'b0, addr_q} + 6'd1);
                    cnt_q  <= cnt_q - 5'd1;
                end
                ST_COMPUTE: begin
                    regs[c_idx] <= mac_result;
                    if (col_q == 2'd2) begin
                        col_q <= 2'd0;
                        row_q <= compute_last ? 2'd0 : row_q + 2'd1;
                    end else begin
                        col_q <= col_q + 2'd1;
                    end
                    if (compute_last) begin
                        done_out <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
